// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer (master) and the shared datapath (slave).
// mem_ready: the memory port completed the access presented this cycle; the sequencer holds its strobes until it sees it.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       zero;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdest;
  logic       regwrite;
  logic       jal;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsource;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  opcode, mem_ready, zero,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdest, regwrite, jal, alusrca, alusrcb, aluop, pcsource, state, illegal
  );

  modport slave (
    output opcode, mem_ready, zero,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdest, regwrite, jal, alusrca, alusrcb, aluop, pcsource, state, illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer stepping the shared MIPS-lite datapath through fetch/decode/execute/memory/writeback.
// Controls are registered from the next state; only the fetch loads are qualified by mem_ready.
module mips_multicycle_ctrl (
  input  logic                          clk,
  input  logic                          rst_n,
  mips_multicycle_ctrl_if.master        bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_NORIEX  = 4'd9,
    S_NORIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       fetch_ld;
    logic       memtoreg;
    logic       regdest;
    logic       regwrite;
    logic       jal;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_NORI = 6'b001101;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_JSP  = 6'b010010;

  function automatic logic f_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_NORI) || (op == OP_JAL) || (op == OP_JSP);
  endfunction

  function automatic state_t f_next(input state_t s, input logic [5:0] op, input logic rdy);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:   n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   n = S_MEMADDR;
          OP_R:           n = S_EXEC;
          OP_BEQ:         n = S_BRANCH;
          OP_NORI:        n = S_NORIEX;
          OP_JAL, OP_JSP: n = S_JUMP;
          default:        n = S_FETCH;
        endcase
      end
      S_MEMADDR: n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   n = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   n = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:    n = S_RWB;
      S_NORIEX:  n = S_NORIWB;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  // Opcode only matters in JUMP; the IR is frozen outside FETCH so it is stable here.
  function automatic ctl_t f_decode(input state_t s, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memread  = 1'b1;
        c.fetch_ld = 1'b1;
        c.alusrcb  = 2'b01;
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADDR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_RWB: begin
        c.regwrite = 1'b1;
        c.regdest  = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
      end
      S_NORIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = 2'b11;
      end
      S_NORIWB:  c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcwrite = 1'b1;
        if (op == OP_JAL) begin
          c.pcsource = 2'b10;
          c.regwrite = 1'b1;
          c.jal      = 1'b1;
        end else begin
          c.pcsource = 2'b11;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t r_state;
  ctl_t   r_ctl;
  logic   r_illegal;
  state_t w_next;

  always_comb begin
    w_next = f_next(r_state, bus.opcode, bus.mem_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_ctl     <= f_decode(S_FETCH, 6'd0);
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctl   <= f_decode(w_next, bus.opcode);
      if (r_state == S_DECODE && !f_legal(bus.opcode)) begin
        r_illegal <= 1'b1;
      end
    end
  end

  assign bus.pcwrite     = r_ctl.pcwrite | (r_ctl.fetch_ld & bus.mem_ready);
  assign bus.irwrite     = r_ctl.fetch_ld & bus.mem_ready;
  assign bus.pcwritecond = r_ctl.pcwritecond;
  assign bus.iord        = r_ctl.iord;
  assign bus.memread     = r_ctl.memread;
  assign bus.memwrite    = r_ctl.memwrite;
  assign bus.memtoreg    = r_ctl.memtoreg;
  assign bus.regdest     = r_ctl.regdest;
  assign bus.regwrite    = r_ctl.regwrite;
  assign bus.jal         = r_ctl.jal;
  assign bus.alusrca     = r_ctl.alusrca;
  assign bus.alusrcb     = r_ctl.alusrcb;
  assign bus.aluop       = r_ctl.aluop;
  assign bus.pcsource    = r_ctl.pcsource;
  assign bus.state       = r_state;
  assign bus.illegal     = r_illegal;

endmodule
